sobel_max_tracker: RTL and testbench
====================================

# sobel_max_tracker

Converts per-lane signed Sobel gradients (gx, gy) into saturated L1 magnitudes at NUM_PER_CYCLE pixels per cycle. It streams the magnitudes downstream and tracks the frame-wide maximum over the ROI interior, excluding a MASK_SIZE border. It sits directly upstream of max_mask:
- `dout`/`dout_valid` feed max_mask's `din`/`din_valid`.
- `max` feeds max_mask's `max` divisor and is held stable for a whole frame.

## Interface
- ROI_SIZE, 480, ROI width = height in pixels; ROI_SIZE % NUM_PER_CYCLE == 0.
- IN_WIDTH, 12, signed width of gx/gy.
- OUT_WIDTH, 12, width of magnitude and max outputs.
- MASK_SIZE, 6, border width excluded from max search, in pixels.
- NUM_PER_CYCLE, 2, pixels per beat; lane 0 is the lower column index.
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- clk_en  in  1  global stall; when low, all state freezes.
- gx  in  signed [IN_WIDTH-1:0] x [NUM_PER_CYCLE]  horizontal gradient per lane.
- gy  in  signed [IN_WIDTH-1:0] x [NUM_PER_CYCLE]  vertical gradient per lane.
- din_valid  in  1  beat qualifier.
- dout  out  [OUT_WIDTH-1:0] x [NUM_PER_CYCLE]  saturated magnitude per lane.
- dout_valid  out  1  dout qualifier.
- max  out  signed [OUT_WIDTH-1:0]  interior maximum of the last completed frame.
- max_valid  out  1  one-cycle pulse when `max` updates.

## Operation
- A beat is accepted when clk_en && din_valid. Non-accepted cycles advance nothing; gaps inside a frame are legal.
- Stage 1, per lane:
  - a = |gx|, b = |gy|, each IN_WIDTH bits unsigned; |-2^(IN_WIDTH-1)| = 2^(IN_WIDTH-1), no overflow.
  - s = a + b, IN_WIDTH+1 bits.
  - Saturate s to SAT = 2^(OUT_WIDTH-1)-1 (2047 at defaults), so magnitude is always a positive signed value for the divider.
- Stage 2: register the magnitudes into `dout`, assert `dout_valid`, and update the running max.
- Position counters col (steps by NUM_PER_CYCLE) and row advance on each accepted beat:
  - col wraps at ROI_SIZE and increments row.
  - The frame ends on the beat with row = ROI_SIZE-1 and col = ROI_SIZE-NUM_PER_CYCLE (ROI_SIZE²/NUM_PER_CYCLE beats). Counters then wrap to 0,0.
- Interior lane pixel: MASK_SIZE <= row <= ROI_SIZE-MASK_SIZE-1 and MASK_SIZE <= col+lane <= ROI_SIZE-MASK_SIZE-1.
- Only interior lanes update run_max = max(run_max, mag). Lanes are compared in the same cycle, and ties keep the existing value.
- On the last frame beat reaching stage 2:
  - max <= max(run_max including that beat, 1). The floor of 1 prevents divide-by-zero downstream.
  - max_valid pulses.
  - run_max clears to 0 for the next frame.
- `max` holds its value between updates.

## Timing
- Reset values: dout = 0 all lanes, dout_valid = 0, max = 0, max_valid = 0, run_max = 0, row = col = 0, pipeline valids = 0.
- Latency: a beat accepted at edge k appears on dout with dout_valid = 1 after edge k+2, provided clk_en is high at both edges.
- dout_valid is high for exactly one cycle per accepted beat, with no duplication or loss.
- max_valid is asserted in the same cycle as the dout_valid of the frame's last beat.
- clk_en low: pipeline registers, counters and run_max hold. dout_valid and max_valid hold their current values, and downstream must also gate on clk_en. No beat is accepted.
- rst mid-frame: all state returns to reset values at the next edge. In-flight beats are discarded. The next accepted beat is row 0, col 0.
- Back-to-back frames need no idle cycle. The first beat of frame N+1 may be accepted in the cycle after frame N's last beat.

## Test plan
All scenarios use ROI_SIZE=8, MASK_SIZE=1, NUM_PER_CYCLE=2, IN_WIDTH=OUT_WIDTH=12 (32 beats/frame) unless stated.
- Magnitude arithmetic:
  - gx = -2048, gy = 0 -> dout = 2047 (saturated).
  - gx = 300, gy = -200 -> dout = 500.
  - gx = gy = 1500 -> 2047.
  - Each result appears 2 cycles after acceptance.
- Border exclusion: all-zero frame except border pixel (row 0, col 3) = 1000 and interior pixel (row 3, col 4) = 700 -> max = 700; max_valid pulses once, aligned with the 32nd dout_valid.
- Zero frame: all gradients 0 -> max = 1, max_valid = 1; all dout = 0.
- Gaps and stalls: a random frame with din_valid deasserted ~30% and clk_en low ~20% -> dout stream equals the no-gap reference, and max matches the model.
- Back-to-back frames: frame 1 max 900, frame 2 max 400 -> max = 900 after frame 1, then 400; run_max does not carry over.
- Reset mid-frame: assert rst at beat 13 of a frame, then send a full frame with max 321 -> no max_valid from the aborted frame; max = 321 after 32 beats.

Source files
------------

// File: rtl/sobel_max_tracker_if.sv
// sobel_max_tracker_if: gradient beats in, magnitudes and frame max out.
// master drives gradients, slave is the tracker.
interface sobel_max_tracker_if #(
    parameter int IN_WIDTH      = 12,
    parameter int OUT_WIDTH     = 12,
    parameter int NUM_PER_CYCLE = 2
);
    logic signed [IN_WIDTH-1:0]  gx [NUM_PER_CYCLE];
    logic signed [IN_WIDTH-1:0]  gy [NUM_PER_CYCLE];
    logic                        din_valid;
    logic        [OUT_WIDTH-1:0] dout [NUM_PER_CYCLE];
    logic                        dout_valid;
    logic signed [OUT_WIDTH-1:0] max;
    logic                        max_valid;

    modport master (
        output gx, gy, din_valid,
        input  dout, dout_valid, max, max_valid
    );

    modport slave (
        input  gx, gy, din_valid,
        output dout, dout_valid, max, max_valid
    );
endinterface

// File: rtl/sobel_max_tracker.sv
// sobel_max_tracker: saturated L1 gradient magnitude per lane, plus the
// frame-wide maximum over the ROI interior for a downstream divider.
module sobel_max_tracker #(
    parameter int ROI_SIZE      = 480,
    parameter int IN_WIDTH      = 12,
    parameter int OUT_WIDTH     = 12,
    parameter int MASK_SIZE     = 6,
    parameter int NUM_PER_CYCLE = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clk_en,
    sobel_max_tracker_if.slave bus
);
    localparam int NPC = NUM_PER_CYCLE;
    localparam int CW  = $clog2(ROI_SIZE);
    localparam int SAT = 2**(OUT_WIDTH-1) - 1;
    localparam int LO  = MASK_SIZE;
    localparam int HI  = ROI_SIZE - MASK_SIZE - 1;

    logic                 accept;
    logic [CW-1:0]        row_q, col_q, row_d, col_d;
    logic                 last_d;
    logic [NPC-1:0]       int_d;

    // stage 0: absolute values captured at acceptance
    logic [IN_WIDTH-1:0]  a_d  [NPC];
    logic [IN_WIDTH-1:0]  b_d  [NPC];
    logic [IN_WIDTH-1:0]  a0_q [NPC];
    logic [IN_WIDTH-1:0]  b0_q [NPC];
    logic                 v0_q, last0_q;
    logic [NPC-1:0]       int0_q;

    // stage 1: saturated magnitudes
    logic [OUT_WIDTH-1:0] mag_d  [NPC];
    logic [OUT_WIDTH-1:0] mag1_q [NPC];
    logic                 v1_q, last1_q;
    logic [NPC-1:0]       int1_q;

    // stage 2: outputs and running maximum
    logic [OUT_WIDTH-1:0] dout_q [NPC];
    logic                 dv_q, mv_q;
    logic [OUT_WIDTH-1:0] max_q, max_d;
    logic [OUT_WIDTH-1:0] run_max_q, run_max_d;

    assign accept = clk_en && bus.din_valid;

    // position of the incoming beat, its interior lanes and end-of-frame
    always_comb begin
        logic row_in;
        row_d  = row_q;
        col_d  = col_q + CW'(NPC);
        last_d = (row_q == CW'(ROI_SIZE-1)) && (col_q == CW'(ROI_SIZE-NPC));
        if (col_q == CW'(ROI_SIZE-NPC)) begin
            col_d = '0;
            row_d = (row_q == CW'(ROI_SIZE-1)) ? '0 : row_q + CW'(1);
        end
        row_in = (int'(row_q) >= LO) && (int'(row_q) <= HI);
        int_d  = '0;
        for (int l = 0; l < NPC; l++) begin
            int_d[l] = row_in && (int'(col_q) + l >= LO) &&
                       (int'(col_q) + l <= HI);
        end
    end

    // absolute value; the most negative input maps to 2^(IN_WIDTH-1)
    always_comb begin
        for (int l = 0; l < NPC; l++) begin
            a_d[l] = bus.gx[l][IN_WIDTH-1] ?
                     (~bus.gx[l] + IN_WIDTH'(1)) : bus.gx[l];
            b_d[l] = bus.gy[l][IN_WIDTH-1] ?
                     (~bus.gy[l] + IN_WIDTH'(1)) : bus.gy[l];
        end
    end

    // sum and clamp so the magnitude stays a positive signed value
    always_comb begin
        logic [IN_WIDTH:0] s;
        for (int l = 0; l < NPC; l++) begin
            s = {1'b0, a0_q[l]} + {1'b0, b0_q[l]};
            mag_d[l] = (32'(s) > 32'(SAT)) ? OUT_WIDTH'(SAT)
                                           : OUT_WIDTH'(s);
        end
    end

    // interior lanes update the max; ties keep the held value
    always_comb begin
        logic [OUT_WIDTH-1:0] m;
        m = run_max_q;
        for (int l = 0; l < NPC; l++) begin
            if (int1_q[l] && (mag1_q[l] > m)) begin
                m = mag1_q[l];
            end
        end
        max_d     = (m == '0) ? OUT_WIDTH'(1) : m;
        run_max_d = last1_q ? '0 : m;
    end

    // row/col counters advance on every accepted beat
    always_ff @(posedge clk) begin
        if (rst) begin
            row_q <= '0;
            col_q <= '0;
        end else if (accept) begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    // stage 0 register: capture |gx|, |gy| and position flags
    always_ff @(posedge clk) begin
        if (rst) begin
            v0_q    <= 1'b0;
            last0_q <= 1'b0;
            int0_q  <= '0;
            for (int l = 0; l < NPC; l++) begin
                a0_q[l] <= '0;
                b0_q[l] <= '0;
            end
        end else if (clk_en) begin
            v0_q <= bus.din_valid;
            if (bus.din_valid) begin
                last0_q <= last_d;
                int0_q  <= int_d;
                for (int l = 0; l < NPC; l++) begin
                    a0_q[l] <= a_d[l];
                    b0_q[l] <= b_d[l];
                end
            end
        end
    end

    // stage 1 register: saturated magnitudes
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q    <= 1'b0;
            last1_q <= 1'b0;
            int1_q  <= '0;
            for (int l = 0; l < NPC; l++) begin
                mag1_q[l] <= '0;
            end
        end else if (clk_en) begin
            v1_q <= v0_q;
            if (v0_q) begin
                last1_q <= last0_q;
                int1_q  <= int0_q;
                for (int l = 0; l < NPC; l++) begin
                    mag1_q[l] <= mag_d[l];
                end
            end
        end
    end

    // stage 2 register: stream out, track max, publish on frame end
    always_ff @(posedge clk) begin
        if (rst) begin
            dv_q      <= 1'b0;
            mv_q      <= 1'b0;
            max_q     <= '0;
            run_max_q <= '0;
            for (int l = 0; l < NPC; l++) begin
                dout_q[l] <= '0;
            end
        end else if (clk_en) begin
            dv_q <= v1_q;
            mv_q <= v1_q && last1_q;
            if (v1_q) begin
                run_max_q <= run_max_d;
                for (int l = 0; l < NPC; l++) begin
                    dout_q[l] <= mag1_q[l];
                end
                if (last1_q) begin
                    max_q <= max_d;
                end
            end
        end
    end

    assign bus.dout       = dout_q;
    assign bus.dout_valid = dv_q;
    assign bus.max        = max_q;
    assign bus.max_valid  = mv_q;
endmodule

// File: tb/tb_sobel_max_tracker.sv
// tb_sobel_max_tracker: directed checks of magnitude, latency, border
// exclusion, stalls, back-to-back frames and mid-frame reset.
module tb_sobel_max_tracker;
    localparam int NPC   = 2;
    localparam int BEATS = 32;

    logic clk = 1'b0;
    logic rst;
    logic clk_en;

    sobel_max_tracker_if #(
        .IN_WIDTH(12), .OUT_WIDTH(12), .NUM_PER_CYCLE(NPC)
    ) bus ();

    sobel_max_tracker #(
        .ROI_SIZE(8), .IN_WIDTH(12), .OUT_WIDTH(12),
        .MASK_SIZE(1), .NUM_PER_CYCLE(NPC)
    ) dut (
        .clk(clk), .rst(rst), .clk_en(clk_en), .bus(bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int fgx [BEATS][NPC];
    int fgy [BEATS][NPC];
    int q0 [$];
    int q1 [$];
    int qmax [$];
    int qidx [$];

    // collect every consumed output beat and max pulse
    always @(negedge clk) begin
        if (!rst && clk_en) begin
            if (bus.dout_valid) begin
                q0.push_back(int'(bus.dout[0]));
                q1.push_back(int'(bus.dout[1]));
            end
            if (bus.max_valid) begin
                qmax.push_back(int'(bus.max));
                qidx.push_back(q0.size() - 1);
            end
        end
    end

    function automatic int ref_mag(input int x, input int y);
        int s;
        s = (x < 0 ? -x : x) + (y < 0 ? -y : y);
        return (s > 2047) ? 2047 : s;
    endfunction

    function automatic bit interior(input int b, input int l);
        int r, c;
        r = b / 4;
        c = (b % 4) * 2 + l;
        return (r >= 1) && (r <= 6) && (c >= 1) && (c <= 6);
    endfunction

    function automatic int model_max();
        int m;
        m = 0;
        for (int b = 0; b < BEATS; b++)
            for (int l = 0; l < NPC; l++)
                if (interior(b, l) && ref_mag(fgx[b][l], fgy[b][l]) > m)
                    m = ref_mag(fgx[b][l], fgy[b][l]);
        return (m == 0) ? 1 : m;
    endfunction

    task automatic clear_frame();
        for (int b = 0; b < BEATS; b++)
            for (int l = 0; l < NPC; l++) begin
                fgx[b][l] = 0;
                fgy[b][l] = 0;
            end
    endtask

    task automatic clear_q();
        q0.delete();
        q1.delete();
        qmax.delete();
        qidx.delete();
    endtask

    task automatic idle(input int n);
        bus.din_valid = 1'b0;
        clk_en = 1'b1;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input int nb, input bit gaps);
        for (int b = 0; b < nb; b++) begin
            bit done;
            int tries;
            done  = 1'b0;
            tries = 0;
            while (!done) begin
                bit ce, dv;
                ce = !gaps || ($urandom_range(0, 99) >= 20) || tries > 20;
                dv = !gaps || ($urandom_range(0, 99) >= 30) || tries > 20;
                for (int l = 0; l < NPC; l++) begin
                    bus.gx[l] = 12'(fgx[b][l]);
                    bus.gy[l] = 12'(fgy[b][l]);
                end
                bus.din_valid = dv;
                clk_en = ce;
                @(posedge clk);
                #1;
                done = ce && dv;
                tries++;
            end
        end
        bus.din_valid = 1'b0;
        clk_en = 1'b1;
    endtask

    task automatic check_stream(input string nm);
        total++;
        if (q0.size() !== BEATS) begin
            bad++;
            $display("FAIL %s count: got %0d want %0d", nm, q0.size(), BEATS);
        end
        for (int i = 0; i < q0.size() && i < BEATS; i++) begin
            int e0, e1;
            e0 = ref_mag(fgx[i][0], fgy[i][0]);
            e1 = ref_mag(fgx[i][1], fgy[i][1]);
            total++;
            if (q0[i] !== e0 || q1[i] !== e1) begin
                bad++;
                $display("FAIL %s beat %0d: got %0d/%0d want %0d/%0d",
                         nm, i, q0[i], q1[i], e0, e1);
            end
        end
    endtask

    task automatic check_max(input string nm, input int want);
        total++;
        if (qmax.size() !== 1) begin
            bad++;
            $display("FAIL %s pulses: got %0d want 1", nm, qmax.size());
        end else begin
            total++;
            if (qmax[0] !== want) begin
                bad++;
                $display("FAIL %s max: got %0d want %0d", nm, qmax[0], want);
            end
            total++;
            if (qidx[0] !== BEATS - 1) begin
                bad++;
                $display("FAIL %s align: got %0d want %0d",
                         nm, qidx[0], BEATS - 1);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clk_en = 1'b1;
        bus.din_valid = 1'b0;
        for (int l = 0; l < NPC; l++) begin
            bus.gx[l] = '0;
            bus.gy[l] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (bus.dout_valid !== 1'b0 || bus.max_valid !== 1'b0 ||
            bus.max !== 12'sd0 || bus.dout[0] !== 12'd0 ||
            bus.dout[1] !== 12'd0) begin
            bad++;
            $display("FAIL reset: dv=%b mv=%b max=%0d d0=%0d d1=%0d want 0s",
                     bus.dout_valid, bus.max_valid, bus.max,
                     bus.dout[0], bus.dout[1]);
        end
        rst = 1'b0;
    endtask

    task automatic test_magnitude();
        int vx [2][NPC];
        int vy [2][NPC];
        int ex [2][NPC];
        vx = '{'{-2048, 300}, '{1500, -1}};
        vy = '{'{0, -200},    '{1500, -1}};
        ex = '{'{2047, 500},  '{2047, 2}};
        for (int v = 0; v < 2; v++) begin
            for (int l = 0; l < NPC; l++) begin
                bus.gx[l] = 12'(vx[v][l]);
                bus.gy[l] = 12'(vy[v][l]);
            end
            bus.din_valid = 1'b1;
            @(posedge clk);
            #1;
            bus.din_valid = 1'b0;
            bus.gx[0] = 12'sd77;
            @(posedge clk);
            #1;
            total++;
            if (bus.dout_valid !== 1'b0) begin
                bad++;
                $display("FAIL mag%0d early: dv=%b want 0", v, bus.dout_valid);
            end
            @(posedge clk);
            #1;
            total++;
            if (bus.dout_valid !== 1'b1 || int'(bus.dout[0]) !== ex[v][0] ||
                int'(bus.dout[1]) !== ex[v][1]) begin
                bad++;
                $display("FAIL mag%0d: dv=%b got %0d/%0d want 1 %0d/%0d", v,
                         bus.dout_valid, bus.dout[0], bus.dout[1],
                         ex[v][0], ex[v][1]);
            end
            @(posedge clk);
            #1;
            total++;
            if (bus.dout_valid !== 1'b0) begin
                bad++;
                $display("FAIL mag%0d dup: dv=%b want 0", v, bus.dout_valid);
            end
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_border();
        clear_frame();
        fgx[1][1]  = 1000;
        fgx[14][0] = 350;
        fgy[14][0] = -350;
        fgx[4][1]  = 600;
        fgx[31][1] = 2000;
        clear_q();
        send_frame(BEATS, 1'b0);
        idle(6);
        check_stream("border");
        check_max("border", 700);
    endtask

    task automatic test_zero_frame();
        clear_frame();
        clear_q();
        send_frame(BEATS, 1'b0);
        idle(6);
        check_stream("zero");
        check_max("zero", 1);
    endtask

    task automatic test_gaps_stalls();
        clear_frame();
        for (int b = 0; b < BEATS; b++)
            for (int l = 0; l < NPC; l++) begin
                fgx[b][l] = int'($urandom_range(0, 2400)) - 1200;
                fgy[b][l] = int'($urandom_range(0, 2400)) - 1200;
            end
        clear_q();
        send_frame(BEATS, 1'b1);
        idle(6);
        check_stream("gaps");
        check_max("gaps", model_max());
    endtask

    task automatic test_back_to_back();
        clear_q();
        clear_frame();
        fgx[9][0] = 900;
        fgx[0][0] = 1200;
        send_frame(BEATS, 1'b0);
        clear_frame();
        fgy[22][1] = -400;
        fgx[7][1]  = 1800;
        send_frame(BEATS, 1'b0);
        idle(6);
        total++;
        if (q0.size() !== 2 * BEATS || qmax.size() !== 2) begin
            bad++;
            $display("FAIL b2b counts: beats=%0d pulses=%0d want 64 2",
                     q0.size(), qmax.size());
        end else begin
            total++;
            if (qmax[0] !== 900 || qmax[1] !== 400) begin
                bad++;
                $display("FAIL b2b max: got %0d,%0d want 900,400",
                         qmax[0], qmax[1]);
            end
            total++;
            if (qidx[0] !== 31 || qidx[1] !== 63) begin
                bad++;
                $display("FAIL b2b align: got %0d,%0d want 31,63",
                         qidx[0], qidx[1]);
            end
        end
        total++;
        if (bus.max !== 12'sd400) begin
            bad++;
            $display("FAIL b2b hold: got %0d want 400", bus.max);
        end
    endtask

    task automatic test_reset_mid();
        clear_frame();
        fgx[5][0] = 1900;
        send_frame(13, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        total++;
        if (bus.dout_valid !== 1'b0 || bus.max !== 12'sd0 ||
            bus.max_valid !== 1'b0) begin
            bad++;
            $display("FAIL midrst state: dv=%b max=%0d mv=%b want 0 0 0",
                     bus.dout_valid, bus.max, bus.max_valid);
        end
        clear_q();
        clear_frame();
        fgx[27][0] = 321;
        send_frame(BEATS, 1'b0);
        idle(6);
        check_stream("midrst");
        check_max("midrst", 321);
    endtask

    initial begin
        test_reset();
        test_magnitude();
        test_border();
        test_zero_frame();
        test_gaps_stalls();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
